vga_plot_arbiter: RTL and testbench

- Shares the single pixel-write port of vga_adapter (x, y, colour, plot) among four drawing engines: screen clear/fill, circle, square and diamond.
- Grants one engine at a time for a whole shape (burst), using round-robin between shapes.
- Registers each accepted pixel and drives plot for one cycle, clipping off-screen pixels.
- Has an optional slow mode that paces pixel acceptance for visible drawing.

---
 rtl/vga_plot_arbiter_if.sv | 39 +++
 rtl/vga_plot_arbiter.sv | 144 ++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_plot_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_plot_arbiter_if
// Description : Requester-side pixel bus shared by the four drawing engines
//               and the plot arbiter. Each engine owns one slot of the packed
//               x/y/colour vectors.
//   req       : per-requester request, held while a pixel is presented
//   last      : presented pixel is the final pixel of the shape
//   x_in      : requester i x at [8i+7:8i]
//   y_in      : requester i y at [7i+6:7i]
//   colour_in : requester i colour at [CW*i+CW-1:CW*i]
//   gnt       : one-hot registered grant
//   ack       : combinational, high in the cycle a pixel is accepted
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_plot_arbiter_if #(
    parameter int CW = 3
);
    logic [3:0]      req;
    logic [3:0]      last;
    logic [31:0]     x_in;
    logic [27:0]     y_in;
    logic [4*CW-1:0] colour_in;
    logic [3:0]      gnt;
    logic [3:0]      ack;

    // Drawing engines
    modport master (
        output req, last, x_in, y_in, colour_in,
        input  gnt, ack
    );

    // Arbiter
    modport slave (
        input  req, last, x_in, y_in, colour_in,
        output gnt, ack
    );
endinterface
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_plot_arbiter
// Description : Shares the vga_adapter pixel-write port among four drawing
//               engines. One engine is granted for a whole shape (burst),
//               round-robin between shapes. Accepted pixels are registered and
//               strobed on plot for one cycle; off-screen pixels are dropped
//               and flagged on clipped. Optional slow pacing for visible
//               drawing.
//   CLOCK_50 : system clock (rising edge)
//   resetn   : asynchronous active-low reset
//   slow     : 1 = accept at most one pixel per SLOW_DIV cycles
//   bus      : requester bus (req/last/x_in/y_in/colour_in/gnt/ack)
//   x, y, colour, plot : registered pixel write to vga_adapter
//   busy     : high while a burst is in progress
//   clipped  : one-cycle pulse in place of plot for an off-screen pixel
// Revision    : 1.0 - initial release
// ============================================================================
module vga_plot_arbiter #(
    parameter int SLOW_DIV = 1000000,
    parameter int XMAX     = 159,
    parameter int YMAX     = 119,
    parameter int CW       = 3
) (
    input  wire logic           CLOCK_50,
    input  wire logic           resetn,
    input  wire logic           slow,
    vga_plot_arbiter_if.slave   bus,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [CW-1:0]       colour,
    output logic                plot,
    output logic                busy,
    output logic                clipped
);
    localparam int CNT_W = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    logic [3:0]       gnt_q;
    logic [1:0]       last_winner;   // also the current owner while in BURST
    logic [CNT_W-1:0] count;

    logic [1:0]    win;
    logic          tick;
    logic          accept;
    logic [3:0]    ack_w;
    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [CW-1:0] sel_colour;
    logic          onscreen;

    // Round-robin pick: first requesting slot after the previous winner.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        win   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_winner + 2'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign tick       = !slow || (count == CNT_W'(SLOW_DIV - 1));
    assign accept     = (state == BURST) && bus.req[last_winner] && tick;
    assign ack_w      = accept ? (4'b0001 << last_winner) : 4'b0000;
    assign sel_x      = bus.x_in[{last_winner, 3'b000} +: 8];
    assign sel_y      = bus.y_in[7*last_winner +: 7];
    assign sel_colour = bus.colour_in[CW*last_winner +: CW];
    assign onscreen   = (sel_x <= 8'(XMAX)) && (sel_y <= 7'(YMAX));

    assign bus.ack = ack_w;
    assign bus.gnt = gnt_q;
    assign busy    = (state == BURST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            gnt_q       <= 4'b0000;
            last_winner <= 2'd3;
            count       <= '0;
            plot        <= 1'b0;
            clipped     <= 1'b0;
            x           <= 8'd0;
            y           <= 7'd0;
            colour      <= '0;
        end else begin
            plot    <= 1'b0;
            clipped <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (|bus.req) begin
                        state       <= BURST;
                        gnt_q       <= 4'b0001 << win;
                        last_winner <= win;
                    end
                end
                BURST: begin
                    // Divider runs only in slow mode; restarts from 0 when slow rises.
                    if (slow)
                        count <= tick ? '0 : count + CNT_W'(1);
                    else
                        count <= '0;

                    if (!bus.req[last_winner]) begin
                        // Requester abandoned its shape: release without plotting.
                        state <= IDLE;
                        gnt_q <= 4'b0000;
                    end else if (accept) begin
                        if (onscreen) begin
                            plot   <= 1'b1;
                            x      <= sel_x;
                            y      <= sel_y;
                            colour <= sel_colour;
                        end else begin
                            // Pixel coordinates on the adapter bus are kept
                            // for the last visible pixel only.
                            clipped <= 1'b1;
                        end
                        if (bus.last[last_winner]) begin
                            state <= IDLE;
                            gnt_q <= 4'b0000;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= 4'b0000;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_plot_arbiter
// Description : Self-checking bench for vga_plot_arbiter: hand-written vector
//               table, directed multi-cycle sequences and randomized traffic
//               compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_plot_arbiter;
    localparam int SLOW_DIV = 4;
    localparam int CW       = 3;

    logic          CLOCK_50;
    logic          resetn;
    logic          slow;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [CW-1:0] colour;
    logic          plot;
    logic          busy;
    logic          clipped;

    int checks   = 0;
    int failures = 0;

    vga_plot_arbiter_if #(.CW(CW)) bus ();

    vga_plot_arbiter #(
        .SLOW_DIV (SLOW_DIV),
        .XMAX     (159),
        .YMAX     (119),
        .CW       (CW)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .slow     (slow),
        .bus      (bus.slave),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .clipped  (clipped)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_owner;      // -1 = no shape in progress
    int         m_prev;       // slot granted most recently
    int         m_wait;       // cycles spent waiting in slow mode since last pixel/rise
    logic       m_plot, m_clip;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_col;

    function automatic logic [7:0] slot_x(int i);  return bus.x_in[8*i +: 8];  endfunction
    function automatic logic [6:0] slot_y(int i);  return bus.y_in[7*i +: 7];  endfunction
    function automatic logic [2:0] slot_c(int i);  return bus.colour_in[3*i +: 3]; endfunction

    function automatic logic m_ready();
        return !slow || (m_wait == SLOW_DIV - 1);
    endfunction

    function automatic logic [3:0] m_ack();
        if (m_owner >= 0 && bus.req[m_owner] && m_ready()) return 4'(1 << m_owner);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_prev = 3; m_wait = 0;
        m_plot = 0; m_clip = 0; m_x = 0; m_y = 0; m_col = 0;
    endtask

    // Advance model by one clock edge using the inputs present before the edge.
    task automatic model_step();
        logic acc;
        acc    = (m_ack() != 4'b0000);
        m_plot = 0;
        m_clip = 0;
        if (m_owner < 0) begin
            m_wait = 0;
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && bus.req[(m_prev + k) % 4]) m_owner = (m_prev + k) % 4;
            end
            if (m_owner >= 0) m_prev = m_owner;
        end else begin
            m_wait = (slow && !m_ready()) ? m_wait + 1 : 0;
            if (!bus.req[m_owner]) begin
                m_owner = -1;
            end else if (acc) begin
                if (slot_x(m_owner) <= 159 && slot_y(m_owner) <= 119) begin
                    m_plot = 1;
                    m_x = slot_x(m_owner); m_y = slot_y(m_owner); m_col = slot_c(m_owner);
                end else begin
                    m_clip = 1;
                end
                if (bus.last[m_owner]) m_owner = -1;
            end
        end
    endtask

    logic [3:0] obs_ack, obs_gnt;
    logic       obs_plot;

    // One clock: called at the falling edge with inputs already driven.
    task automatic cycle();
        logic [3:0] eg;
        #1;
        check("ack", 32'(bus.ack), 32'(m_ack()));
        obs_ack = bus.ack;
        @(posedge CLOCK_50);
        model_step();
        #1;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        check("gnt", 32'(bus.gnt), 32'(eg));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("plot", 32'(plot), 32'(m_plot));
        check("clipped", 32'(clipped), 32'(m_clip));
        if (m_plot) begin
            check("x", 32'(x), 32'(m_x));
            check("y", 32'(y), 32'(m_y));
            check("colour", 32'(colour), 32'(m_col));
        end
        obs_gnt  = bus.gnt;
        obs_plot = plot;
        @(negedge CLOCK_50);
    endtask

    task automatic drive_all(input logic [3:0] r, input logic [3:0] l,
                             input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        bus.req = r;
        bus.last = l;
        bus.x_in = {4{px}};
        bus.y_in = {4{py}};
        bus.colour_in = {4{pc}};
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        drive_all(4'b0, 4'b0, 8'd0, 7'd0, 3'd0);
        slow = 1'b0;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic [3:0] e_ack;
        logic [3:0] e_gnt;
        logic       e_plot;
        logic       e_clip;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_col;
    } vec_t;

    vec_t vt[7];

    initial begin
        int pix, ackc, first_ack, prev_ack_cyc, plots;
        logic [3:0] prev_g;
        int order[$];

        resetn = 1'b0;
        slow   = 1'b0;
        drive_all(4'b0, 4'b0, 8'd0, 7'd0, 3'd0);
        model_reset();

        // ---- reset state ----
        #1;
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_plot", 32'(plot), 0);
        check("rst_clipped", 32'(clipped), 0);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_colour", 32'(colour), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // ---- vector table: single pixel shape, then clipped + corner pixel ----
        //         req      last     px     py     pc    ack      gnt      plot clip x      y      col
        vt[0] = '{4'b0001, 4'b0001, 8'd5,   7'd7,   3'd3, 4'b0000, 4'b0001, 0, 0, 8'd0,   7'd0,   3'd0};
        vt[1] = '{4'b0001, 4'b0001, 8'd5,   7'd7,   3'd3, 4'b0001, 4'b0000, 1, 0, 8'd5,   7'd7,   3'd3};
        vt[2] = '{4'b0000, 4'b0000, 8'd5,   7'd7,   3'd3, 4'b0000, 4'b0000, 0, 0, 8'd5,   7'd7,   3'd3};
        vt[3] = '{4'b0001, 4'b0000, 8'd160, 7'd0,   3'd1, 4'b0000, 4'b0001, 0, 0, 8'd5,   7'd7,   3'd3};
        vt[4] = '{4'b0001, 4'b0000, 8'd160, 7'd0,   3'd1, 4'b0001, 4'b0001, 0, 1, 8'd0,   7'd0,   3'd0};
        vt[5] = '{4'b0001, 4'b0001, 8'd159, 7'd119, 3'd5, 4'b0001, 4'b0000, 1, 0, 8'd159, 7'd119, 3'd5};
        vt[6] = '{4'b0000, 4'b0000, 8'd0,   7'd0,   3'd0, 4'b0000, 4'b0000, 0, 0, 8'd159, 7'd119, 3'd5};
        for (int i = 0; i < 7; i++) begin
            drive_all(vt[i].req, vt[i].last, vt[i].px, vt[i].py, vt[i].pc);
            #1;
            check("tbl_ack", 32'(bus.ack), 32'(vt[i].e_ack));
            @(posedge CLOCK_50);
            #1;
            check("tbl_gnt", 32'(bus.gnt), 32'(vt[i].e_gnt));
            check("tbl_plot", 32'(plot), 32'(vt[i].e_plot));
            check("tbl_clipped", 32'(clipped), 32'(vt[i].e_clip));
            if (vt[i].e_plot || i == 2 || i == 3) begin
                check("tbl_x", 32'(x), 32'(vt[i].e_x));
                check("tbl_y", 32'(y), 32'(vt[i].e_y));
                check("tbl_colour", 32'(colour), 32'(vt[i].e_col));
            end
            @(negedge CLOCK_50);
        end

        // ---- two requesters, 4-pixel shape then round-robin ----
        apply_reset();
        pix = 0; plots = 0; prev_g = 4'b0;
        for (int c = 0; c < 14; c++) begin
            drive_all(4'b0101, {1'b0, 1'b1, 1'b0, pix >= 3}, 8'(10 + c), 7'(20 + c), 3'(c));
            cycle();
            if (obs_ack[0]) pix++;
            if (obs_plot && order.size() == 1) plots++;
            if (obs_gnt != 4'b0 && prev_g == 4'b0) order.push_back($clog2(obs_gnt));
            prev_g = obs_gnt;
        end
        check("rr_plots_req0", 32'(plots), 4);
        check("rr_order_len", 32'(order.size() >= 3), 1);
        if (order.size() >= 3) begin
            check("rr_first", 32'(order[0]), 0);
            check("rr_second", 32'(order[1]), 2);
            check("rr_third", 32'(order[2]), 0);
        end

        // ---- slow mode: three pixels from requester 1 ----
        apply_reset();
        slow = 1'b1;
        pix = 0; ackc = 0; first_ack = -1; prev_ack_cyc = -1;
        for (int c = 0; c < 30 && pix < 3; c++) begin
            drive_all(4'b0010, {2'b00, pix == 2, 1'b0}, 8'(40 + pix), 7'(50 + pix), 3'd6);
            cycle();
            if (obs_ack[1]) begin
                if (prev_ack_cyc >= 0) check("slow_ack_spacing", 32'(c - prev_ack_cyc), SLOW_DIV);
                else first_ack = c;
                prev_ack_cyc = c;
                pix++;
                check("slow_plot_after_ack", 32'(obs_plot), 1);
            end
        end
        check("slow_pixels_done", 32'(pix), 3);
        check("slow_first_ack", 32'(first_ack), SLOW_DIV);
        slow = 1'b0;

        // ---- requester 3 aborts after 2 pixels; requester 0 waiting ----
        apply_reset();
        plots = 0; pix = 0;
        for (int c = 0; c < 8; c++) begin
            if (pix < 2) drive_all(4'b1000, 4'b0000, 8'(90 + c), 7'(9), 3'd2);
            else         drive_all(4'b0001, 4'b0000, 8'd1, 7'd1, 3'd1);
            cycle();
            if (obs_ack[3]) pix++;
            if (obs_plot && obs_gnt != 4'b0001) plots++;
            if (c == 5) check("abort_regrant_req0", 32'(obs_gnt), 32'(4'b0001));
        end
        check("abort_plots", 32'(plots), 2);

        // ---- reset while a pixel is in flight ----
        apply_reset();
        drive_all(4'b0001, 4'b0001, 8'd3, 7'd3, 3'd3);
        cycle();
        #1;
        check("inflight_ack", 32'(bus.ack), 32'(4'b0001));
        resetn = 1'b0;
        model_reset();
        #1;
        check("rst_mid_plot", 32'(plot), 0);
        check("rst_mid_gnt", 32'(bus.gnt), 0);
        @(posedge CLOCK_50);
        #1;
        check("rst_mid_plot_edge", 32'(plot), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        drive_all(4'b0110, 4'b0000, 8'd0, 7'd0, 3'd0);
        cycle();
        check("rst_first_grant", 32'(obs_gnt), 32'(4'b0010));

        // ---- randomized traffic vs model ----
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r;
            r = bus.req;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            end
            bus.req  = r;
            bus.last = 4'($urandom) & 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                bus.x_in[8*i +: 8]  = 8'($urandom_range(0, 200));
                bus.y_in[7*i +: 7]  = 7'($urandom_range(0, 127));
                bus.colour_in[3*i +: 3] = 3'($urandom);
            end
            if ($urandom_range(0, 39) == 0) slow = ~slow;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
